// File: rtl/sprite_motion_scheduler.sv
// Sprite motion scheduler: once per frame (during vertical blanking) walks every
// sprite through one shared add/compare path, applies its velocity, and then
// bounces it off the screen edges (collidable) or wraps it modulo 128
// (non-collidable).
// Optional build macro: SPRITE_SCHED_FRAMESKIP_EN. When it is defined, a motion
// step happens only once every FRAME_DIV accepted frame_start pulses.
module sprite_motion_scheduler #(
    parameter int         NUM_SPRITES = 4,
    parameter logic [7:0] SCREEN_W    = 8'd128,
    parameter logic [7:0] SCREEN_H    = 8'd128,
    parameter logic [3:0] FRAME_DIV   = 4'd1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_start,
    input  logic [14*NUM_SPRITES-1:0]  dims,
    input  logic [NUM_SPRITES-1:0]     collidable,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [2:0]                 cfg_idx,
    input  logic [6:0]                 cfg_x,
    input  logic [6:0]                 cfg_y,
    input  logic [3:0]                 cfg_vx,
    input  logic [3:0]                 cfg_vy,
    output logic [7*NUM_SPRITES-1:0]   xPos_bus,
    output logic [7*NUM_SPRITES-1:0]   yPos_bus,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_SPRITES-1:0]     bounced,
    output logic                       overrun
);

    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPRITES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC_X,
        CALC_Y,
        WRITE,
        FIN
    } state_t;

    state_t         state;
    logic [IW-1:0]  idx;

    logic [6:0]     x_reg  [NUM_SPRITES];
    logic [6:0]     y_reg  [NUM_SPRITES];
    logic [3:0]     vx_reg [NUM_SPRITES];
    logic [3:0]     vy_reg [NUM_SPRITES];

    logic [6:0]     dim_w  [NUM_SPRITES];
    logic [6:0]     dim_h  [NUM_SPRITES];

    logic [6:0]     work_x;
    logic [6:0]     work_y;
    logic [3:0]     work_vx;
    logic [3:0]     work_vy;
    logic [6:0]     work_w;
    logic [6:0]     work_h;
    logic           work_coll;
    logic           hit_x;
    logic           hit_y;

    logic           step_frame;
    logic           start_sweep;
    logic           cfg_hit;

    // One axis of motion: returns {reflected, new velocity, new position}.
    // The sum is kept 9 bits wide and signed so a step past either border is
    // visible before it is clipped or wrapped back into 7 bits.
    function automatic logic [11:0] axis_step(
        input logic [6:0] pos,
        input logic [3:0] vel,
        input logic [6:0] size,
        input logic [7:0] limit,
        input logic       coll
    );
        logic [8:0]  np;
        logic [6:0]  sz;
        logic [3:0]  vneg;
        logic [9:0]  far_edge;
        logic [11:0] result;
        np       = {2'b00, pos} + {{5{vel[3]}}, vel};
        sz       = (size == 7'd0) ? 7'd1 : size;
        vneg     = (vel == 4'b1000) ? 4'b0111 : (4'd0 - vel);
        far_edge = {1'b0, np} + {3'b000, sz};
        result   = {1'b0, vel, np[6:0]};
        if (coll) begin
            if (np[8]) begin
                result = {1'b1, vneg, 7'd0};
            end else if (far_edge > {2'b00, limit}) begin
                result = {1'b1, vneg, 7'(limit - {1'b0, sz})};
            end
        end
        return result;
    endfunction

`ifdef SPRITE_SCHED_FRAMESKIP_EN
    localparam logic [3:0] STEP_LAST = (FRAME_DIV == 4'd0) ? 4'd0 : (FRAME_DIV - 4'd1);
    logic [3:0] frame_cnt;

    // A frame only produces a motion step once the skip counter has wrapped.
    always_comb begin
        step_frame = (frame_cnt == STEP_LAST);
    end
`else
    // FRAME_DIV has no effect when frame skipping is compiled out.
    logic unused_frame_div;
    assign unused_frame_div = ^FRAME_DIV;

    // Every frame_start seen in IDLE produces a motion step.
    always_comb begin
        step_frame = 1'b1;
    end
`endif

    // Decode sweep start and config acceptance from the current state.
    always_comb begin
        start_sweep = (state == IDLE) && frame_start && step_frame;
        cfg_hit     = cfg_valid && cfg_ready && (32'(cfg_idx) < NUM_SPRITES);
    end

    // Flatten position registers onto the buses and unpack per-sprite dimensions.
    always_comb begin
        xPos_bus = '0;
        yPos_bus = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            xPos_bus[7*i +: 7] = x_reg[i];
            yPos_bus[7*i +: 7] = y_reg[i];
            dim_w[i]           = dims[14*i+7 +: 7];
            dim_h[i]           = dims[14*i +: 7];
        end
    end

    // Sweep sequencer, config write port and sticky status, all in one register block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bounced   <= '0;
            overrun   <= 1'b0;
            cfg_ready <= 1'b1;
            work_x    <= '0;
            work_y    <= '0;
            work_vx   <= '0;
            work_vy   <= '0;
            work_w    <= '0;
            work_h    <= '0;
            work_coll <= 1'b0;
            hit_x     <= 1'b0;
            hit_y     <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_reg[i]  <= '0;
                y_reg[i]  <= '0;
                vx_reg[i] <= '0;
                vy_reg[i] <= '0;
            end
`ifdef SPRITE_SCHED_FRAMESKIP_EN
            frame_cnt <= 4'd0;
`endif
        end else begin
            done <= 1'b0;

            if (frame_start && busy) begin
                overrun <= 1'b1;
            end

            if (cfg_hit) begin
                x_reg[cfg_idx[IW-1:0]]  <= cfg_x;
                y_reg[cfg_idx[IW-1:0]]  <= cfg_y;
                vx_reg[cfg_idx[IW-1:0]] <= cfg_vx;
                vy_reg[cfg_idx[IW-1:0]] <= cfg_vy;
            end

            case (state)
                IDLE: begin
`ifdef SPRITE_SCHED_FRAMESKIP_EN
                    if (frame_start) begin
                        frame_cnt <= step_frame ? 4'd0 : (frame_cnt + 4'd1);
                    end
`endif
                    if (start_sweep) begin
                        idx       <= '0;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                        bounced   <= '0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    work_x    <= x_reg[idx];
                    work_y    <= y_reg[idx];
                    work_vx   <= vx_reg[idx];
                    work_vy   <= vy_reg[idx];
                    work_w    <= dim_w[idx];
                    work_h    <= dim_h[idx];
                    work_coll <= collidable[idx];
                    state     <= CALC_X;
                end
                CALC_X: begin
                    {hit_x, work_vx, work_x} <= axis_step(work_x, work_vx, work_w, SCREEN_W, work_coll);
                    state <= CALC_Y;
                end
                CALC_Y: begin
                    {hit_y, work_vy, work_y} <= axis_step(work_y, work_vy, work_h, SCREEN_H, work_coll);
                    state <= WRITE;
                end
                WRITE: begin
                    x_reg[idx]   <= work_x;
                    y_reg[idx]   <= work_y;
                    vx_reg[idx]  <= work_vx;
                    vy_reg[idx]  <= work_vy;
                    bounced[idx] <= hit_x | hit_y;
                    if (idx == LAST_IDX) begin
                        state <= FIN;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= LOAD;
                    end
                end
                FIN: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_scheduler.sv
// Directed bench for sprite_motion_scheduler with the default four sprites.
// Sprites 1 and 3 are collidable; sprite 3 has zero dimensions so its edge
// behaves as a one-pixel sprite.
module tb_sprite_motion_scheduler;

`ifdef SPRITE_SCHED_FRAMESKIP_EN
    localparam logic [3:0] frameDiv = 4'd3;
`else
    localparam logic [3:0] frameDiv = 4'd1;
`endif

    logic        clk;
    logic        reset;
    logic        frameStart;
    logic [55:0] dimsVec;
    logic [3:0]  collVec;
    logic        cfgValid;
    logic        cfgReady;
    logic [2:0]  cfgIdx;
    logic [6:0]  cfgX;
    logic [6:0]  cfgY;
    logic [3:0]  cfgVx;
    logic [3:0]  cfgVy;
    logic [27:0] xBus;
    logic [27:0] yBus;
    logic        busy;
    logic        done;
    logic [3:0]  bounced;
    logic        overrun;

    int totalChecks;
    int badChecks;
    int latency;
    int pulses;
    int busySeen;

    sprite_motion_scheduler #(
        .NUM_SPRITES (4),
        .SCREEN_W    (8'd128),
        .SCREEN_H    (8'd128),
        .FRAME_DIV   (frameDiv)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frameStart),
        .dims        (dimsVec),
        .collidable  (collVec),
        .cfg_valid   (cfgValid),
        .cfg_ready   (cfgReady),
        .cfg_idx     (cfgIdx),
        .cfg_x       (cfgX),
        .cfg_y       (cfgY),
        .cfg_vx      (cfgVx),
        .cfg_vy      (cfgVy),
        .xPos_bus    (xBus),
        .yPos_bus    (yBus),
        .busy        (busy),
        .done        (done),
        .bounced     (bounced),
        .overrun     (overrun)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack four 7-bit sprite values into bus order, sprite 0 in the low bits.
    function automatic logic [31:0] pack4(input logic [6:0] s0, input logic [6:0] s1,
                                          input logic [6:0] s2, input logic [6:0] s3);
        return {4'b0000, s3, s2, s1, s0};
    endfunction

    // Compare one observed value against its expectation and tally it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    // One config write from a negedge; the port is idle so it is taken on the next edge.
    task automatic applyStimulus(input logic [2:0] idx, input logic [6:0] x, input logic [6:0] y,
                                 input logic [3:0] vx, input logic [3:0] vy);
        cfgIdx   = idx;
        cfgX     = x;
        cfgY     = y;
        cfgVx    = vx;
        cfgVy    = vy;
        cfgValid = 1'b1;
        @(negedge clk);
        cfgValid = 1'b0;
    endtask

    // Pulse frame_start and count negedges until done, with a bounded wait.
    task automatic runSweep(output int lat);
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Watch a window of cycles for any done pulse or busy activity.
    task automatic watchQuiet(input int cycles, output int donePulses, output int busyCycles);
        donePulses = 0;
        busyCycles = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) donePulses++;
            if (busy) busyCycles++;
        end
    endtask

    // Main sequence.
    initial begin
        totalChecks = 0;
        badChecks   = 0;
        reset       = 1'b1;
        frameStart  = 1'b0;
        cfgValid    = 1'b0;
        cfgIdx      = 3'd0;
        cfgX        = 7'd0;
        cfgY        = 7'd0;
        cfgVx       = 4'd0;
        cfgVy       = 4'd0;
        dimsVec     = {7'd0, 7'd0, 7'd4, 7'd4, 7'd16, 7'd8, 7'd5, 7'd5};
        collVec     = 4'b1010;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state.
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_ready", 32'(cfgReady), 32'd1);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        checkOutput("reset_bounced", 32'(bounced), 32'd0);
        checkOutput("reset_xpos", 32'(xBus), 32'd0);
        checkOutput("reset_ypos", 32'(yBus), 32'd0);

        // Load all four sprites, plus one write to a non-existent index.
        applyStimulus(3'd0, 7'd10, 7'd20, 4'sd3, -4'sd2);
        applyStimulus(3'd1, 7'd110, 7'd50, 4'sd5, 4'sd0);
        applyStimulus(3'd2, 7'd126, 7'd1, 4'sd4, -4'sd3);
        applyStimulus(3'd3, 7'd3, 7'd126, -4'sd8, 4'sd2);
        applyStimulus(3'd5, 7'd99, 7'd99, 4'sd1, 4'sd1);
        checkOutput("cfg_xpos", 32'(xBus), pack4(7'd10, 7'd110, 7'd126, 7'd3));
        checkOutput("cfg_ypos", 32'(yBus), pack4(7'd20, 7'd50, 7'd1, 7'd126));

`ifndef SPRITE_SCHED_FRAMESKIP_EN
        // First sweep: plain move, right-edge bounce, wraps, -8 saturation, zero-size bottom edge.
        runSweep(latency);
        checkOutput("sweep1_latency", 32'(latency), 32'd17);
        checkOutput("sweep1_busy", 32'(busy), 32'd0);
        checkOutput("sweep1_xpos", 32'(xBus), pack4(7'd13, 7'd112, 7'd2, 7'd0));
        checkOutput("sweep1_ypos", 32'(yBus), pack4(7'd18, 7'd50, 7'd126, 7'd127));
        checkOutput("sweep1_bounced", 32'(bounced), 32'b1010);
        @(negedge clk);
        checkOutput("sweep1_done_width", 32'(done), 32'd0);

        // Second sweep: reflected velocities carry the bounced sprites back inward.
        runSweep(latency);
        checkOutput("sweep2_latency", 32'(latency), 32'd17);
        checkOutput("sweep2_xpos", 32'(xBus), pack4(7'd16, 7'd107, 7'd6, 7'd7));
        checkOutput("sweep2_ypos", 32'(yBus), pack4(7'd16, 7'd50, 7'd123, 7'd125));
        checkOutput("sweep2_bounced", 32'(bounced), 32'b0000);
        @(negedge clk);

        // Third sweep with a stray frame_start and a config write held across it.
        cfgIdx     = 3'd0;
        cfgX       = 7'd60;
        cfgY       = 7'd60;
        cfgVx      = 4'd0;
        cfgVy      = 4'd0;
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        cfgValid   = 1'b1;
        checkOutput("sweep3_busy", 32'(busy), 32'd1);
        checkOutput("sweep3_ready_low", 32'(cfgReady), 32'd0);
        latency = 0;
        while (!done && latency < 40) begin
            @(negedge clk);
            latency++;
            if (latency == 4) frameStart = 1'b1;
            if (latency == 5) frameStart = 1'b0;
        end
        checkOutput("sweep3_latency", 32'(latency), 32'd17);
        checkOutput("sweep3_overrun", 32'(overrun), 32'd1);
        checkOutput("sweep3_ready_back", 32'(cfgReady), 32'd1);
        checkOutput("sweep3_xpos", 32'(xBus), pack4(7'd19, 7'd102, 7'd10, 7'd14));
        checkOutput("sweep3_ypos", 32'(yBus), pack4(7'd14, 7'd50, 7'd120, 7'd123));
        @(negedge clk);
        cfgValid = 1'b0;
        checkOutput("late_cfg_xpos", 32'(xBus), pack4(7'd60, 7'd102, 7'd10, 7'd14));
        checkOutput("late_cfg_ypos", 32'(yBus), pack4(7'd60, 7'd50, 7'd120, 7'd123));
        watchQuiet(25, pulses, busySeen);
        checkOutput("no_second_sweep", 32'(pulses), 32'd0);
        checkOutput("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a sweep throws the partial sweep away.
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_overrun", 32'(overrun), 32'd0);
        checkOutput("midreset_ready", 32'(cfgReady), 32'd1);
        checkOutput("midreset_xpos", 32'(xBus), 32'd0);
        checkOutput("midreset_ypos", 32'(yBus), 32'd0);
        watchQuiet(25, pulses, busySeen);
        checkOutput("midreset_no_done", 32'(pulses), 32'd0);
`else
        // Frame skipping by three: the first two frame_starts leave everything still.
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        watchQuiet(20, pulses, busySeen);
        checkOutput("skip1_busy", 32'(busySeen), 32'd0);
        checkOutput("skip1_done", 32'(pulses), 32'd0);
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        watchQuiet(20, pulses, busySeen);
        checkOutput("skip2_busy", 32'(busySeen), 32'd0);
        checkOutput("skip2_done", 32'(pulses), 32'd0);
        checkOutput("skip_xpos", 32'(xBus), pack4(7'd10, 7'd110, 7'd126, 7'd3));
        runSweep(latency);
        checkOutput("skip3_latency", 32'(latency), 32'd17);
        checkOutput("skip3_xpos", 32'(xBus), pack4(7'd13, 7'd112, 7'd2, 7'd0));
        checkOutput("skip3_ypos", 32'(yBus), pack4(7'd18, 7'd50, 7'd126, 7'd127));
        checkOutput("skip3_bounced", 32'(bounced), 32'b1010);
`endif

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/sprite_motion_scheduler.md
Name: sprite_motion_scheduler

Overview:
- Time-multiplexed position sequencer for up to NUM_SPRITES sprite instances on the 128x128 grid. Each instance uses 7-bit xPos/yPos and 14-bit address {y,x}.
- On each frame_start pulse, walks sprites 0..NUM_SPRITES-1 through one shared adder/compare path. Applies per-sprite velocity, then bounces (collidable) or wraps (non-collidable) at the screen borders.
- Drives the xPos/yPos inputs of the sprite instances. Positions only change between frame_start and done, i.e. during blanking.

Parameters:
- NUM_SPRITES, 4, number of sprites scheduled (1..8).
- SCREEN_W, 8'd128, screen width in pixels.
- SCREEN_H, 8'd128, screen height in pixels.
- FRAME_DIV, 4'd1, frames per motion step. Used only with SPRITE_SCHED_FRAMESKIP_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- dims  in  14*NUM_SPRITES  per-sprite {WIDTH[6:0],HEIGHT[6:0]}; sprite i at [14i+13:14i]
- collidable  in  NUM_SPRITES  per-sprite isCollidable
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config accepted when cfg_valid&&cfg_ready
- cfg_idx  in  3  sprite index to configure
- cfg_x, cfg_y  in  7 each  new position
- cfg_vx, cfg_vy  in  4 each  signed velocity, range -8..+7
- xPos_bus, yPos_bus  out  7*NUM_SPRITES  current positions; sprite i at [7i+6:7i]
- busy  out  1  update sweep in progress
- done  out  1  one-cycle pulse when sweep completes
- bounced  out  NUM_SPRITES  bit i set if sprite i reflected in last sweep
- overrun  out  1  sticky: frame_start arrived while busy

Behaviour:
- Reset: all positions 0, velocities 0, busy=0, done=0, bounced=0, overrun=0, cfg_ready=1, FSM=IDLE.
- FSM states:
  - IDLE: cfg_ready=1. On frame_start go to LOAD with idx=0, busy=1, bounced cleared.
  - LOAD: latch sprite idx position, velocity, dims and collidable into working regs.
  - CALC_X: nx = {1'b0,x} + sign_ext(vx), 9-bit signed.
  - CALC_Y: same for y using vy.
  - WRITE: commit results; set bounced[idx] if either axis reflected. If idx==NUM_SPRITES-1 go to FIN, else idx+1 and go to LOAD.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Latency: frame_start to done pulse = 4*NUM_SPRITES+1 cycles (17 for default).
- Collidable axis rule, X shown (Y identical with H/SCREEN_H):
  - nx<0: x=0, vx=-vx.
  - nx+W>SCREEN_W: x=SCREEN_W-W, vx=-vx.
  - otherwise x=nx[6:0].
  - Negation of -8 saturates to +7.
  - W=0 is treated as W=1.
- Non-collidable axis rule: x=nx[6:0] (modulo-128 wrap), velocity unchanged.
- Config handshake:
  - cfg_ready=0 whenever busy; requester holds cfg_valid until accepted.
  - Accepted write updates position and velocity of cfg_idx in the same cycle.
  - cfg_idx>=NUM_SPRITES: write accepted and discarded.
  - cfg write and frame_start in the same IDLE cycle: write commits first; sweep uses new values.
- frame_start while busy: ignored, overrun set. overrun clears only on reset.
- Reset mid-sweep: immediate return to IDLE with all registers at reset values. A partial sweep is not retained.
- Positions are updated in place; no sprite's bus field changes outside its WRITE cycle.

Optional Feature:
- Macro: SPRITE_SCHED_FRAMESKIP_EN.
- Defined:
  - A 4-bit frame counter counts frame_start pulses accepted in IDLE.
  - A sweep starts only when the counter reaches FRAME_DIV-1, then the counter resets to 0.
  - Non-stepping frame_starts produce no busy and no done. FRAME_DIV=0 is treated as 1.
  - Counter reset value is 0.
- Undefined: every frame_start accepted in IDLE starts a sweep. FRAME_DIV is ignored.

Test Plan:
1. Reset, then cfg sprite0 x=10,y=20,vx=+3,vy=-2. Pulse frame_start. Expect done exactly 17 cycles later, sprite0=(13,18), bounced=0.
2. Collidable sprite1, W=16, x=110, vx=+5. Sweep. Expect x=112, vx=-5, bounced[1]=1. Next sweep: x=107.
3. Non-collidable sprite2, x=126, vx=+4. Sweep. Expect x=2 (wrap). Also y=1, vy=-3 → y=126.
4. Pulse frame_start again at cycle 5 of a sweep. Expect overrun=1, done still at cycle 17, no second sweep. Hold cfg_valid during sweep: cfg_ready=0 until IDLE, write lands after done.
5. Assert reset at cycle 9 of a sweep. Next cycle: busy=0, all positions 0, overrun=0. No done pulse.
6. With SPRITE_SCHED_FRAMESKIP_EN and FRAME_DIV=3: three frame_starts give exactly one sweep, on the third.
